debounce_multi: RTL

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

---
 rtl/debounce_multi.sv | 113 +++++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: N_CH independent push-button debouncers with
// 2-flop sync, press/release edge pulses and a one-shot long-press pulse.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst_n      - synchronous active-low reset
//   tick       - sample enable for the stability and hold counters
//   pb_in      - raw asynchronous button levels [N_CH]
//   pb_deb     - debounced, registered button state [N_CH]
//   press      - one-clk pulse on each debounced 0->1 [N_CH]
//   release_o  - one-clk pulse on each debounced 1->0 [N_CH]
//   long_press - one-clk pulse after HOLD_CNT ticks held [N_CH]
module debounce_multi #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STABLE_CNT = 16,
    parameter int unsigned HOLD_CNT   = 1000,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] pb_deb,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_press
);

    localparam int unsigned SW = $clog2(STABLE_CNT + 1);
    localparam int unsigned HW = $clog2(HOLD_CNT + 1);

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CNT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);

    logic [N_CH-1:0] s1_q, s1_d;
    logic [N_CH-1:0] s2_q, s2_d;
    logic [N_CH-1:0] deb_q, deb_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] rel_q, rel_d;
    logic [N_CH-1:0] long_q, long_d;
    logic [N_CH-1:0] flip;

    logic [N_CH-1:0][SW-1:0] stab_q, stab_d;
    logic [N_CH-1:0][HW-1:0] hold_q, hold_d;

    always_comb begin
        s1_d    = (ACTIVE_LOW != 0) ? ~pb_in : pb_in;
        s2_d    = s1_q;
        deb_d   = deb_q;
        press_d = '0;
        rel_d   = '0;
        long_d  = '0;
        flip    = '0;
        stab_d  = stab_q;
        hold_d  = hold_q;

        for (int ch = 0; ch < N_CH; ch++) begin
            // Stability counter: counts consecutive disagreeing ticks.
            if (tick) begin
                if (s2_q[ch] == deb_q[ch]) begin
                    stab_d[ch] = '0;
                end else if (stab_q[ch] == STAB_LAST) begin
                    flip[ch]   = 1'b1;
                    stab_d[ch] = '0;
                end else begin
                    stab_d[ch] = stab_q[ch] + SW'(1);
                end
            end

            deb_d[ch]   = deb_q[ch] ^ flip[ch];
            press_d[ch] = flip[ch] & ~deb_q[ch];
            rel_d[ch]   = flip[ch] & deb_q[ch];

            // A falling edge clears the hold count on the same edge,
            // which also keeps long_press out of the release cycle.
            if (!deb_q[ch] || flip[ch]) begin
                hold_d[ch] = '0;
            end else if (tick && hold_q[ch] != HOLD_MAX) begin
                hold_d[ch] = hold_q[ch] + HW'(1);
                long_d[ch] = (hold_q[ch] == HOLD_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            stab_q  <= '0;
            hold_q  <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            stab_q  <= stab_d;
            hold_q  <= hold_d;
        end
    end

    assign pb_deb     = deb_q;
    assign press      = press_q;
    assign release_o  = rel_q;
    assign long_press = long_q;

endmodule
